// File: rtl/hps_link_master_if.sv
// -----------------------------------------------------------------------------
// hps_link_master_if
//   The 32-bit host link word pair between the link master (HPS side) and the
//   coprocessor-side manager.
//
//   link_out : master -> device. [0] data flag, [3:1] op, [11:4] A, [19:12] B,
//              [30] result ack, all other bits 0.
//   link_in  : device -> master. [0] element ack, [8:0]/[17:9]/[26:18] results,
//              [30] result valid.
//
//   Modports: master (drives link_out), slave (drives link_in).
// -----------------------------------------------------------------------------
interface hps_link_master_if;
   logic [31:0] link_out;
   logic [31:0] link_in;

   modport master (output link_out, input  link_in);
   modport slave  (input  link_out, output link_in);
endinterface

// File: rtl/hps_link_master.sv
// -----------------------------------------------------------------------------
// hps_link_master
//   Hardware initiator for the host link. Streams N_ELEM (A, B) element pairs
//   plus an opcode to the device using the flag/ack handshake, then collects
//   the nine-bit results (8 triple words and 1 single word), acknowledging each
//   word. Used for standalone bring-up and self-test in place of the HPS.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   start_i, opcode_i     begin a transaction (sampled in IDLE/ERR), opcode
//   elem_addr_o           index of the next element to send
//   elem_a_i, elem_b_i    A/B[elem_addr_o], combinational read
//   link                  link word pair (master modport)
//   res_we_o              one-cycle result write strobe
//   res_idx_o             base index of the written results
//   res_data_o            captured link_in[26:0]
//   res_cnt_o             valid results in res_data_o (3 or 1)
//   busy_o, done_o        transaction in progress / one-cycle completion pulse
//   error_o               sticky timeout flag
// -----------------------------------------------------------------------------
module hps_link_master #(
   parameter int TIMEOUT = 65535,   // cycles in SEND/WAIT_RES before error, 0 = never
   parameter int TW      = 16       // timeout counter width
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_i,
   input  logic [2:0]          opcode_i,
   output logic [4:0]          elem_addr_o,
   input  logic [7:0]          elem_a_i,
   input  logic [7:0]          elem_b_i,
   hps_link_master_if.master   link,
   output logic                res_we_o,
   output logic [4:0]          res_idx_o,
   output logic [26:0]         res_data_o,
   output logic [1:0]          res_cnt_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                error_o
);

   // Element count is fixed by the link protocol.
   localparam int             N_ELEM    = 25;
   localparam logic [4:0]     LAST_ADDR = 5'(N_ELEM);
   localparam logic [3:0]     LAST_W    = 4'((N_ELEM - 1) / 3);
   localparam logic [TW-1:0]  TMO_LIM   = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_GAP, S_WAIT_RES, S_ACK3, S_ACKF1, S_ACKF2, S_ERR
   } state_e;

   state_e          state_q, state_d;
   logic [4:0]      addr_q, addr_d;
   logic [3:0]      w_q, w_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [2:0]      op_q, op_d;
   logic [7:0]      a_q, a_d;
   logic [7:0]      b_q, b_d;
   logic            flag_q, flag_d;
   logic            ack_q, ack_d;
   logic            res_we_q, res_we_d;
   logic [4:0]      res_idx_q, res_idx_d;
   logic [26:0]     res_data_q, res_data_d;
   logic [1:0]      res_cnt_q, res_cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            error_q, error_d;
   logic            tmo_hit;

   assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_LIM);

   // NOTE: every variable written here gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      w_d        = w_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      flag_d     = flag_q;
      ack_d      = ack_q;
      res_we_d   = 1'b0;
      res_idx_d  = res_idx_q;
      res_data_d = res_data_q;
      res_cnt_d  = res_cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = error_q;

      case (state_q)
         S_IDLE, S_ERR: begin
            // addr_q is 0 in both states, so elem_a/b_i hold element 0 here.
            if (start_i) begin
               op_d    = opcode_i;
               a_d     = elem_a_i;
               b_d     = elem_b_i;
               flag_d  = 1'b1;
               ack_d   = 1'b0;
               w_d     = '0;
               busy_d  = 1'b1;
               error_d = 1'b0;
               state_d = S_SEND;
            end
         end

         S_SEND: begin
            if (tmo_hit) begin
               state_d = S_ERR;
            end else if (link.link_in[0]) begin
               flag_d  = 1'b0;
               addr_d  = addr_q + 5'd1;
               state_d = S_GAP;
            end
         end

         // Flag is low for exactly this one cycle; the device advances its
         // index on the closing edge.
         S_GAP: begin
            if (addr_q < LAST_ADDR) begin
               flag_d  = 1'b1;
               a_d     = elem_a_i;
               b_d     = elem_b_i;
               state_d = S_SEND;
            end else begin
               addr_d  = '0;
               w_d     = '0;
               state_d = S_WAIT_RES;
            end
         end

         S_WAIT_RES: begin
            if (tmo_hit) begin
               state_d = S_ERR;
            end else if (link.link_in[30]) begin
               res_we_d   = 1'b1;
               res_data_d = link.link_in[26:0];
               res_idx_d  = {w_q, 1'b0} + {1'b0, w_q};   // 3 * w
               ack_d      = 1'b1;
               if (w_q == LAST_W) begin
                  res_cnt_d = 2'd1;
                  state_d   = S_ACKF1;
               end else begin
                  res_cnt_d = 2'd3;
                  state_d   = S_ACK3;
               end
            end
         end

         // Strict one-cycle ack: a longer ack would double-advance the device.
         S_ACK3: begin
            ack_d   = 1'b0;
            w_d     = w_q + 4'd1;
            state_d = S_WAIT_RES;
         end

         // Final word: ack is held one more cycle so the device sees ack with
         // valid low and leaves its result phase.
         S_ACKF1: state_d = S_ACKF2;

         S_ACKF2: begin
            flag_d  = 1'b0;
            ack_d   = 1'b0;
            op_d    = '0;
            a_d     = '0;
            b_d     = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      // Timeout entry: link goes quiet and addr returns to 0 so a restart
      // from ERR reads element 0.
      if (state_d == S_ERR && state_q != S_ERR) begin
         flag_d  = 1'b0;
         ack_d   = 1'b0;
         op_d    = '0;
         a_d     = '0;
         b_d     = '0;
         addr_d  = '0;
         busy_d  = 1'b0;
         error_d = 1'b1;
      end

      // Timeout counter restarts on any state change.
      if (state_d != state_q)
         tmo_d = '0;
      else if (state_q == S_SEND || state_q == S_WAIT_RES)
         tmo_d = tmo_q + 1'b1;
      else
         tmo_d = '0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         w_q        <= '0;
         tmo_q      <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         flag_q     <= 1'b0;
         ack_q      <= 1'b0;
         res_we_q   <= 1'b0;
         res_idx_q  <= '0;
         res_data_q <= '0;
         res_cnt_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         w_q        <= w_d;
         tmo_q      <= tmo_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         flag_q     <= flag_d;
         ack_q      <= ack_d;
         res_we_q   <= res_we_d;
         res_idx_q  <= res_idx_d;
         res_data_q <= res_data_d;
         res_cnt_q  <= res_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign link.link_out = {1'b0, ack_q, 10'd0, b_q, a_q, op_q, flag_q};
   assign elem_addr_o   = addr_q;
   assign res_we_o      = res_we_q;
   assign res_idx_o     = res_idx_q;
   assign res_data_o    = res_data_q;
   assign res_cnt_o     = res_cnt_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign error_o       = error_q;

endmodule

// File: tb/tb_hps_link_master.sv
// -----------------------------------------------------------------------------
// tb_hps_link_master
//   Two masters: dut_a (TIMEOUT=10) and dut_b (TIMEOUT=0 with a 4-bit counter
//   that wraps many times while waiting). A cycle-accurate device model is
//   routed to whichever master `sel` selects; the other sees an idle link.
// -----------------------------------------------------------------------------
module tb_hps_link_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- DUTs
   logic        rst_a = 1'b1, rst_b = 1'b1;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [2:0]  opcode = 3'd0;
   logic        sel = 1'b0;

   logic [4:0]  addr_a, addr_b, idx_a, idx_b;
   logic        we_a, we_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
   logic [26:0] data_a, data_b;
   logic [1:0]  cnt_a, cnt_b;
   logic [31:0] dev_in;

   hps_link_master_if if_a ();
   hps_link_master_if if_b ();

   assign if_a.link_in = sel ? 32'd0 : dev_in;
   assign if_b.link_in = sel ? dev_in : 32'd0;

   hps_link_master #(.TIMEOUT(10), .TW(16)) dut_a (
      .clk(clk), .reset(rst_a), .start_i(start_a), .opcode_i(opcode),
      .elem_addr_o(addr_a), .elem_a_i(8'(addr_a)), .elem_b_i(8'({addr_a, 1'b0})),
      .link(if_a.master), .res_we_o(we_a), .res_idx_o(idx_a), .res_data_o(data_a),
      .res_cnt_o(cnt_a), .busy_o(busy_a), .done_o(done_a), .error_o(err_a));

   hps_link_master #(.TIMEOUT(0), .TW(4)) dut_b (
      .clk(clk), .reset(rst_b), .start_i(start_b), .opcode_i(opcode),
      .elem_addr_o(addr_b), .elem_a_i(8'(addr_b)), .elem_b_i(8'({addr_b, 1'b0})),
      .link(if_b.master), .res_we_o(we_b), .res_idx_o(idx_b), .res_data_o(data_b),
      .res_cnt_o(cnt_b), .busy_o(busy_b), .done_o(done_b), .error_o(err_b));

   // Selected-master view
   logic [31:0] m_lo;
   logic        m_we, m_busy, m_done, m_err;
   logic [4:0]  m_idx;
   logic [26:0] m_data;
   logic [1:0]  m_cnt;
   assign m_lo   = sel ? if_b.link_out : if_a.link_out;
   assign m_we   = sel ? we_b   : we_a;
   assign m_idx  = sel ? idx_b  : idx_a;
   assign m_data = sel ? data_b : data_a;
   assign m_cnt  = sel ? cnt_b  : cnt_a;
   assign m_busy = sel ? busy_b : busy_a;
   assign m_done = sel ? done_b : done_a;
   assign m_err  = sel ? err_b  : err_a;

   // -------------------------------------------------------- device model
   typedef enum logic [1:0] {D_RX, D_TX, D_FIN} dev_st_e;
   dev_st_e     dst = D_RX;
   logic        dev_rst = 1'b1;
   int          dly_cfg = 0;
   int          didx = 0, dw = 0, ddly = 0;
   logic        dack = 1'b0, dval = 1'b0;
   logic [26:0] dword = '0;
   logic [7:0]  dev_a [25];
   logic [7:0]  dev_b [25];
   int          dbl_adv = 0, dev_exits = 0;

   function automatic logic [26:0] pack_word(input int w);
      logic [26:0] r;
      r = '0;
      for (int j = 0; j < 3; j++)
         if (3 * w + j < 25)
            r[9*j +: 9] = 9'(dev_a[3*w+j]) + 9'(dev_b[3*w+j]);
      return r;
   endfunction

   always @(posedge clk) begin
      if (dev_rst) begin
         dst <= D_RX; didx <= 0; dw <= 0; ddly <= 0; dack <= 1'b0; dval <= 1'b0;
      end else begin
         case (dst)
            D_RX: begin
               if (m_lo[0] && !dack) begin
                  dack        <= 1'b1;
                  dev_a[didx] <= m_lo[11:4];
                  dev_b[didx] <= m_lo[19:12];
               end else if (!m_lo[0] && dack) begin
                  dack <= 1'b0;
                  if (didx == 24) begin didx <= 0; ddly <= 0; dst <= D_TX; end
                  else didx <= didx + 1;
               end
            end
            D_TX: begin
               if (dval) begin
                  if (m_lo[30]) begin
                     dval <= 1'b0; dw <= dw + 1; ddly <= 0;
                     if (dw == 8) dst <= D_FIN;
                  end
               end else begin
                  if (m_lo[30]) dbl_adv <= dbl_adv + 1;   // ack without valid
                  if (ddly >= dly_cfg) begin dval <= 1'b1; dword <= pack_word(dw); end
                  else ddly <= ddly + 1;
               end
            end
            D_FIN: if (m_lo[30]) begin dst <= D_RX; dw <= 0; dev_exits <= dev_exits + 1; end
            default: dst <= D_RX;
         endcase
      end
   end

   assign dev_in = {1'b0, dval, 3'd0, (dval ? dword : 27'd0)} | {31'd0, dack};

   // ------------------------------------------------------------- monitor
   logic        mon_clr = 1'b1;
   logic [2:0]  exp_op = 3'd0;
   int          n_rise, gap_bad, op_bad, bits_bad, n_we, n_ack, ack_run, n_done, low_run;
   logic        prev_flag, prev_ack;
   int          ack_len [9];
   logic [4:0]  we_idx  [9];
   logic [1:0]  we_cnt  [9];
   logic [26:0] we_data [9];

   always @(negedge clk) begin
      if (mon_clr) begin
         n_rise = 0; gap_bad = 0; op_bad = 0; bits_bad = 0; n_we = 0; n_ack = 0;
         ack_run = 0; n_done = 0; low_run = 0; prev_flag = 1'b0; prev_ack = 1'b0;
      end else begin
         if (m_lo[0] && !prev_flag) begin
            if (n_rise > 0 && low_run != 1) gap_bad++;
            n_rise++;
         end
         low_run = m_lo[0] ? 0 : low_run + 1;
         if (m_lo[0] && m_lo[3:1] != exp_op) op_bad++;
         if ((m_lo & 32'hBFF0_0000) != 32'd0) bits_bad++;
         if (m_lo[30]) ack_run++;
         else if (prev_ack) begin
            if (n_ack < 9) ack_len[n_ack] = ack_run;
            n_ack++; ack_run = 0;
         end
         if (m_we) begin
            if (n_we < 9) begin
               we_idx[n_we] = m_idx; we_cnt[n_we] = m_cnt; we_data[n_we] = m_data;
            end
            n_we++;
         end
         if (m_done) n_done++;
         prev_flag = m_lo[0];
         prev_ack  = m_lo[30];
      end
   end

   // --------------------------------------------------------------- tasks
   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge clk); #1;
      mon_clr = 1'b0;
   endtask

   task automatic set_start(input logic v);
      start_a = v & ~sel;
      start_b = v & sel;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [26:0] exp_word(input int k);
      logic [26:0] r;
      r = '0;
      for (int j = 0; j < 3; j++)
         if (3 * k + j < 25) r[9*j +: 9] = 9'(3 * (3 * k + j));
      return r;
   endfunction

   task automatic wait_done(input int max_cyc);
      int k;
      k = 0;
      while (!m_done && k < max_cyc) begin tick(1); k++; end
      check("done_seen", 32'(m_done), 32'd1);
   endtask

   // Full transaction on the selected master, checked against C[i] = 3i.
   task automatic run_full(input logic [2:0] op, input bit hold);
      int exits0, ab_bad;
      clear_mon();
      exp_op = op;
      dev_rst = 1'b1; tick(1); dev_rst = 1'b0;
      exits0 = dev_exits;
      opcode = op;
      set_start(1'b1);
      tick(1);
      check("first_word", m_lo, {28'd0, op, 1'b1});
      check("busy_on", 32'(m_busy), 32'd1);
      if (hold) opcode = ~op; else set_start(1'b0);
      wait_done(3000);
      set_start(1'b0);
      tick(4);
      check("flag_rises", 32'(n_rise), 32'd25);
      check("gap_len", 32'(gap_bad), 32'd0);
      check("op_field", 32'(op_bad), 32'd0);
      check("zero_bits", 32'(bits_bad), 32'd0);
      check("we_count", 32'(n_we), 32'd9);
      check("ack_count", 32'(n_ack), 32'd9);
      for (int k = 0; k < 9; k++) begin
         check($sformatf("res_idx%0d", k), 32'(we_idx[k]), 32'(3 * k));
         check($sformatf("res_cnt%0d", k), 32'(we_cnt[k]), (k < 8) ? 32'd3 : 32'd1);
         check($sformatf("res_data%0d", k), 32'(we_data[k]), 32'(exp_word(k)));
         check($sformatf("ack_len%0d", k), 32'(ack_len[k]), (k < 8) ? 32'd1 : 32'd2);
      end
      ab_bad = 0;
      for (int i = 0; i < 25; i++)
         if (dev_a[i] != 8'(i) || dev_b[i] != 8'(2 * i)) ab_bad++;
      check("dev_ab", 32'(ab_bad), 32'd0);
      check("done_once", 32'(n_done), 32'd1);
      check("busy_off", 32'(m_busy), 32'd0);
      check("no_error", 32'(m_err), 32'd0);
      check("link_idle", m_lo, 32'd0);
      check("dbl_adv", 32'(dbl_adv), 32'd0);
      check("dev_exit", 32'(dev_exits - exits0), 32'd1);
      check("dev_idle", 32'(dst), 32'(D_RX));
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      int k, first;
      bit found;

      // Reset state of both masters
      tick(3);
      check("rst_a_link", if_a.link_out, 32'd0);
      check("rst_a_misc", 32'({addr_a, we_a, idx_a, cnt_a, busy_a, done_a, err_a}), 32'd0);
      check("rst_a_data", 32'(data_a), 32'd0);
      check("rst_b_link", if_b.link_out, 32'd0);
      check("rst_b_misc", 32'({addr_b, we_b, idx_b, cnt_b, busy_b, done_b, err_b, data_b}), 32'd0);
      rst_a = 1'b0; rst_b = 1'b0; dev_rst = 1'b0;
      tick(2);

      // Basic full transaction, op = 3
      sel = 1'b0;
      run_full(3'd3, 1'b0);

      // start held through the transaction, opcode changing mid-flight
      run_full(3'd5, 1'b1);

      // Reset during WAIT_RES at w = 4
      clear_mon();
      exp_op = 3'd3;
      dev_rst = 1'b1; tick(1); dev_rst = 1'b0;
      opcode = 3'd3; set_start(1'b1); tick(1); set_start(1'b0);
      k = 0; found = 1'b0;
      while (!found && k < 2000) begin
         tick(1); k++;
         if (m_we && m_idx == 5'd9) found = 1'b1;
      end
      check("reach_w3", 32'(found), 32'd1);
      tick(1);                      // now WAIT_RES with w = 4
      rst_a = 1'b1; dev_rst = 1'b1;
      tick(1);
      check("midrst_link", if_a.link_out, 32'd0);
      check("midrst_misc", 32'({addr_a, we_a, idx_a, cnt_a, busy_a, done_a, err_a}), 32'd0);
      check("midrst_data", 32'(data_a), 32'd0);
      rst_a = 1'b0; dev_rst = 1'b0;
      tick(3);
      check("midrst_nodone", 32'(n_done), 32'd0);
      run_full(3'd3, 1'b0);

      // Timeout: device held in reset never acks element 0
      clear_mon();
      dev_rst = 1'b1;
      exp_op = 3'd1; opcode = 3'd1;
      set_start(1'b1); tick(1); set_start(1'b0);
      first = 0;
      for (int c = 1; c <= 15; c++) begin
         tick(1);
         if (err_a && first == 0) first = c;
      end
      check("tmo_cycles", 32'(first), 32'd11);
      check("tmo_link", if_a.link_out, 32'd0);
      check("tmo_busy", 32'(busy_a), 32'd0);
      check("tmo_no_we", 32'(n_we), 32'd0);
      check("tmo_no_done", 32'(n_done), 32'd0);
      set_start(1'b1); tick(1); set_start(1'b0);
      check("tmo_clear", 32'(err_a), 32'd0);
      check("tmo_restart", if_a.link_out, 32'h0000_0003);
      rst_a = 1'b1; tick(1); rst_a = 1'b0; dev_rst = 1'b0;
      tick(1);

      // TIMEOUT = 0 master with slow result valid; its 4-bit counter wraps
      sel = 1'b1;
      dly_cfg = 100;
      run_full(3'd6, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
